// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register driving a combinational imem and a
// first-word-fall-through prefetch queue of {pc, word} entries feeding decode.
module fetch_unit #(
  parameter int           N        = 64,
  parameter int           DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0,
  localparam int          PW       = $clog2(DEPTH),
  localparam int          CW       = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [N-1:0]  IM_addr,
  input  logic [31:0]   IM_readData,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [N-1:0]  instr_pc,
  output logic [CW-1:0] count
);

  logic [N-1:0]  r_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [N-1:0]  r_q_pc   [DEPTH];
  logic [31:0]   r_q_word [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [N-1:0]  w_redir_pc;

  assign w_pop      = instr_valid & instr_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign w_push     = ~redirect & ((r_count < CW'(DEPTH)) | w_pop);
  assign w_redir_pc = redirect_pc & ~N'(3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_pc     <= w_redir_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + N'(4);
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_word[r_wr_ptr] <= IM_readData;
    end
  end

  assign IM_addr     = r_pc;
  assign instr_valid = (r_count != '0);
  assign instr       = r_q_word[r_rd_ptr];
  assign instr_pc    = r_q_pc[r_rd_ptr];
  assign count       = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem word i = 0x1000 + i, scenario tasks run in order.
module tb_fetch_unit;
  localparam int N = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  IM_addr;
  logic [31:0]   IM_readData;
  logic          redirect = 1'b0;
  logic [N-1:0]  redirect_pc = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic [N-1:0]  instr_pc;
  logic [2:0]    count;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.N(N), .DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .IM_addr(IM_addr), .IM_readData(IM_readData),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .count(count)
  );

  always #5 clk = ~clk;

  assign IM_readData = 32'h1000 + {22'd0, IM_addr[11:2]};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b0; redirect = 1'b0; instr_ready = rdy;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; instr_ready = 1'b1;
    #2;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid act=%0b exp=0", instr_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count act=%0d exp=0", count); end
    checks++; if (IM_addr !== 64'h0) begin failures++; $display("FAIL reset_addr act=%0h exp=0", IM_addr); end
    step();
    reset = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL first_valid act=%0b exp=1", instr_valid); end
    checks++; if (instr !== 32'h1000) begin failures++; $display("FAIL first_instr act=%0h exp=1000", instr); end
    checks++; if (instr_pc !== 64'h0) begin failures++; $display("FAIL first_pc act=%0h exp=0", instr_pc); end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (instr_pc !== 64'(4*k)) begin failures++; $display("FAIL stream_pc k=%0d act=%0h exp=%0h", k, instr_pc, 4*k); end
      checks++; if (instr !== 32'h1000 + 32'(k)) begin failures++; $display("FAIL stream_instr k=%0d act=%0h exp=%0h", k, instr, 32'h1000 + 32'(k)); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count k=%0d act=%0d exp=1", k, count); end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_cnt;
    do_reset(1'b0);
    for (int c = 1; c <= 8; c++) begin
      step();
      exp_cnt = (c < 4) ? 3'(c) : 3'd4;
      checks++; if (count !== exp_cnt) begin failures++; $display("FAIL bp_count c=%0d act=%0d exp=%0d", c, count, exp_cnt); end
      checks++; if (instr_pc !== 64'h0) begin failures++; $display("FAIL bp_head c=%0d act=%0h exp=0", c, instr_pc); end
    end
    checks++; if (IM_addr !== 64'h10) begin failures++; $display("FAIL bp_addr act=%0h exp=10", IM_addr); end
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (!(instr_valid === 1'b1 && instr_pc === 64'(4*i))) begin failures++; $display("FAIL drain_pc i=%0d act=%0h exp=%0h", i, instr_pc, 4*i); end
      checks++; if (instr !== 32'h1000 + 32'(i)) begin failures++; $display("FAIL drain_instr i=%0d act=%0h exp=%0h", i, instr, 32'h1000 + 32'(i)); end
      step();
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL drain_count i=%0d act=%0d exp=4", i, count); end
    end
  endtask

  task automatic test_full_pop();
    do_reset(1'b0);
    repeat (6) step();
    instr_ready = 1'b1;
    #1;
    checks++; if (instr_pc !== 64'h0 || count !== 3'd4) begin failures++; $display("FAIL nocomb_ready pc=%0h cnt=%0d exp=0/4", instr_pc, count); end
    step();
    instr_ready = 1'b0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fullpop_count act=%0d exp=4", count); end
    checks++; if (instr_pc !== 64'h4) begin failures++; $display("FAIL fullpop_head act=%0h exp=4", instr_pc); end
    checks++; if (IM_addr !== 64'h14) begin failures++; $display("FAIL fullpop_addr act=%0h exp=14", IM_addr); end
    step();
    checks++; if (IM_addr !== 64'h14 || instr_pc !== 64'h4) begin failures++; $display("FAIL fullpop_hold addr=%0h pc=%0h exp=14/4", IM_addr, instr_pc); end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (3) step();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL redir_pre_count act=%0d exp=3", count); end
    redirect = 1'b1; redirect_pc = 64'h203;
    #1;
    checks++; if (instr_valid !== 1'b1 || count !== 3'd3) begin failures++; $display("FAIL nocomb_redirect v=%0b cnt=%0d exp=1/3", instr_valid, count); end
    step();
    redirect = 1'b0;
    checks++; if (count !== 3'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush cnt=%0d v=%0b exp=0/0", count, instr_valid); end
    checks++; if (IM_addr !== 64'h200) begin failures++; $display("FAIL redir_addr act=%0h exp=200", IM_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'h200) begin failures++; $display("FAIL redir_pc v=%0b act=%0h exp=200", instr_valid, instr_pc); end
    checks++; if (instr !== 32'h1080) begin failures++; $display("FAIL redir_instr act=%0h exp=1080", instr); end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    repeat (2) step();
    redirect = 1'b1; redirect_pc = 64'h300;
    step();
    redirect_pc = 64'h400;
    step();
    redirect = 1'b0;
    checks++; if (count !== 3'd0 || IM_addr !== 64'h400) begin failures++; $display("FAIL b2b_flush cnt=%0d addr=%0h exp=0/400", count, IM_addr); end
    step();
    checks++; if (instr_pc !== 64'h400 || instr !== 32'h1100) begin failures++; $display("FAIL b2b_head pc=%0h instr=%0h exp=400/1100", instr_pc, instr); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    repeat (2) step();
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL mid_pre_count act=%0d exp=2", count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL mid_async v=%0b cnt=%0d exp=0/0", instr_valid, count); end
    checks++; if (IM_addr !== 64'h0) begin failures++; $display("FAIL mid_addr act=%0h exp=0", IM_addr); end
    step();
    reset = 1'b1; instr_ready = 1'b1;
    step();
    checks++; if (instr_pc !== 64'h0 || instr !== 32'h1000) begin failures++; $display("FAIL mid_restart pc=%0h instr=%0h exp=0/1000", instr_pc, instr); end
    step();
    checks++; if (instr_pc !== 64'h4) begin failures++; $display("FAIL mid_next act=%0h exp=4", instr_pc); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_pc [4];
    logic [31:0]  exp_w  [4];
    exp_pc[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp_w[0] = 32'h13FE;
    exp_pc[1] = 64'hFFFF_FFFF_FFFF_FFFC; exp_w[1] = 32'h13FF;
    exp_pc[2] = 64'h0;                   exp_w[2] = 32'h1000;
    exp_pc[3] = 64'h4;                   exp_w[3] = 32'h1001;
    do_reset(1'b0);
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    redirect = 1'b0;
    repeat (4) step();
    checks++; if (count !== 3'd4 || IM_addr !== 64'h8) begin failures++; $display("FAIL wrap_fill cnt=%0d addr=%0h exp=4/8", count, IM_addr); end
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_pc !== exp_pc[i] || instr !== exp_w[i]) begin failures++; $display("FAIL wrap_entry i=%0d pc=%0h instr=%0h exp=%0h/%0h", i, instr_pc, instr, exp_pc[i], exp_w[i]); end
      step();
    end
    instr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pop();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the pipelined ARM processor. It replaces the bare IF stage: a PC register addressing the instruction memory, plus an internal prefetch queue of depth `DEPTH`. Decode consumes instructions through a valid/ready handshake, and branch resolution redirects fetch with a single-cycle flush. It sits between `imem`, which is combinational (`q` valid in the same cycle as the address), and the IF/ID boundary of the datapath. Each queued instruction travels with its own PC.

## Interface
- `N`, 64, PC and address width.
- `DEPTH`, 4, prefetch queue entries; power of two, ≥ 2.
- `RESET_PC`, 0, first fetch address; bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `IM_addr`  out  N  current fetch PC, driven to `imem` (`imem` uses `IM_addr[11:2]`).
- `IM_readData`  in  32  instruction word at `IM_addr`, combinational from `imem`.
- `redirect`  in  1  branch taken / PC override this cycle.
- `redirect_pc`  in  N  target PC; bits [1:0] are ignored and treated as 0.
- `instr_valid`  out  1  queue head holds a valid instruction.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `instr`  out  32  head instruction word.
- `instr_pc`  out  N  PC of the head instruction.
- `count`  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- **State:**
  - `pc` register, N bits.
  - Circular queue of DEPTH entries, each `{pc[N-1:0], word[31:0]}`.
  - `rd_ptr` and `wr_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` register.
- `IM_addr = pc` at all times.
- **Pop:** occurs when `instr_valid & instr_ready`; `rd_ptr` advances by 1.
  - `instr_ready` while `instr_valid` = 0 has no effect.
- **Push:** occurs when `!redirect & (count < DEPTH | pop)`.
  - Writes `{pc, IM_readData}` at `wr_ptr`, advances `wr_ptr`, and sets `pc <= pc + 4`.
  - When full with a simultaneous pop, the push is allowed, so the queue stays full and streams at 1 instruction per cycle.
- **Stall:** when no push occurs, `pc` holds and the same address is re-presented. No word is ever skipped or duplicated.
- **count update:** +1 on push only, −1 on pop only, unchanged on both or neither.
- **Redirect** has priority over everything in that cycle:
  - The queue is flushed: `count <= 0`, `rd_ptr <= 0`, `wr_ptr <= 0`.
  - `pc <= {redirect_pc[N-1:2], 2'b00}`.
  - No push occurs.
  - A head that is popped in the same cycle is still consumed by decode. Decode is responsible for ignoring it if it is younger than the branch.
- **PC arithmetic:** modulo 2^N; `pc + 4` from `2^N − 4` wraps to 0 with no flag.
- **Output ports:**
  - `instr_valid = (count != 0)`.
  - `instr` and `instr_pc` are driven combinationally from entry `rd_ptr` (first-word fall-through).
  - When `instr_valid` = 0, `instr` and `instr_pc` are don't-care; the bench must not check them.

## Timing
- **Reset** (asynchronous assert, active-low): `pc = RESET_PC`, `count = 0`, both pointers 0, `instr_valid = 0`, `IM_addr = RESET_PC`.
  - Queue contents are not reset.
  - Reset asserted mid-operation discards all queued instructions immediately, with no clock edge needed.
- **Fetch latency:** a word present on `IM_readData` in cycle t is pushed at edge t and visible on `instr` in cycle t+1 (1 cycle).
  - First valid instruction: the first cycle after the first rising edge following reset release.
- **Throughput:** 1 instruction per cycle while `instr_ready` = 1.
- **Redirect penalty:**
  - `redirect` in cycle t gives `instr_valid = 0` in cycle t+1.
  - The target word is fetched in cycle t+1 and appears on `instr` in cycle t+2.
  - Back-to-back redirects: the last one wins, and each one flushes.
- **Backpressure:** with `instr_ready` = 0, the queue fills to DEPTH after DEPTH cycles and `pc` then freezes.
  - With DEPTH = 4 from an empty queue, `pc` advances exactly 4 times.
- `instr_valid`, `instr`, `instr_pc` and `count` change only on clock edges or reset; they have no combinational path from `instr_ready` or `redirect`.

## Test plan
- **Reset and stream:** RESET_PC = 0, imem word i = 0x1000 + i, `instr_ready` = 1.
  - Cycle 1 after release: `instr_valid` = 1, `instr` = 0x1000, `instr_pc` = 0.
  - Then `instr_pc` increments by 4 every cycle, and `count` stays at 1.
- **Backpressure fill:** hold `instr_ready` = 0 for 8 cycles.
  - `count` goes 1, 2, 3, 4 and then holds at 4; `IM_addr` freezes at 16; `instr_pc` stays 0.
  - Release `instr_ready`: PCs 0, 4, 8, 12, 16, … come out in order with no gaps or duplicates.
- **Full with simultaneous pop:** with the queue full, pulse `instr_ready` for 1 cycle.
  - `count` stays 4, head advances by one entry, `IM_addr` advances by 4.
- **Redirect:** in cycle t, assert `redirect` with `redirect_pc` = 0x203 while `count` = 3.
  - Cycle t+1: `count` = 0, `instr_valid` = 0, `IM_addr` = 0x200.
  - Cycle t+2: `instr_pc` = 0x200, `instr` = imem[0x80].
- **Reset mid-stream:** assert `reset` low between clock edges while `count` = 2.
  - `instr_valid` falls immediately and `IM_addr` = RESET_PC.
  - After release, the stream restarts from RESET_PC.
- **PC wrap:** redirect to 2^N − 8 (N = 64).
  - Queue receives PCs 0xFFFF_FFFF_FFFF_FFF8, 0xFFFF_FFFF_FFFF_FFFC, 0x0, 0x4 in order.
